// File: rtl/coh_pkg.sv
// Shared types for the snooping coherence bus.
//   bus_state_e : transaction sequencer states
//   blk_state_e : per-cache block state reported during a snoop
//   idx_w()     : width of a core index for a given core count
package coh_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    RESP  = 3'd2,
    WBACK = 3'd3,
    INVAL = 3'd4,
    FILL  = 3'd5
  } bus_state_e;

  typedef enum logic [1:0] {
    BLK_I = 2'b00,
    BLK_S = 2'b01,
    BLK_M = 2'b10
  } blk_state_e;

  // A single core still needs a 1-bit index so that vectors stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among N requesters, purely combinational.
// Ports:
//   req     in  N      request vector
//   ptr     in  IDX_W  highest-priority index for this pick (must be < N)
//   gnt     out N      one-hot winner (zero when no request)
//   idx     out IDX_W  winner index
//   req_any out 1      at least one request present
module rr_arbiter
  import coh_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             req_any
);

  // Scan from ptr upward, wrapping, and keep the first requester found.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] pos_idx;
    logic             hit;
    gnt     = '0;
    idx     = '0;
    hit     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int off = 0; off < N; off++) begin
      pos     = (int'(ptr) + off) % N;
      pos_idx = IDX_W'(pos);
      if (!hit && req[pos_idx]) begin
        hit          = 1'b1;
        gnt[pos_idx] = 1'b1;
        idx          = pos_idx;
      end
    end
    req_any = hit;
  end

endmodule

// File: rtl/coh_snoop_bus.sv
// N-core snooping coherence bus. Grants cache misses round-robin, broadcasts
// the miss address for snooping, forces a Modified owner to write back,
// invalidates other holders on a write miss and steers the fill to the
// requester.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req_rd/wr    per-core read/write miss, held until done[i]
//   req_addr     per-core miss address, core i at [i*ADDR_W +: ADDR_W]
//   snoop_found  per-cache hit on addr_out (sampled in RESP)
//   snoop_state  per-cache block state, 2 bits each
//   wback_done   memory accepted the owner write-back
//   grant        one-hot bus owner
//   addr_out     latched address of the granted miss
//   search       snoop strobe to all non-owners
//   invalidate   invalidate strobe to holding caches
//   wback        write-back request to the M owner
//   datasel      fill-data steer to the requester
//   busy         transaction in flight
//   done         one-cycle completion pulse to the requester
//
// state | meaning
// IDLE  | waiting for a miss; arbitrate and latch winner/addr/op
// SNOOP | search strobe to every non-owner
// RESP  | sample snoop results, pick M owner if any
// WBACK | owner writes back, wait for wback_done
// INVAL | invalidate every cache that held the block
// FILL  | steer data to requester, pulse done, advance rr pointer
module coh_snoop_bus
  import coh_pkg::*;
#(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CPU-1:0]          req_rd,
  input  logic [NUM_CPU-1:0]          req_wr,
  input  logic [NUM_CPU*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CPU-1:0]          snoop_found,
  input  logic [2*NUM_CPU-1:0]        snoop_state,
  input  logic                        wback_done,
  output logic [NUM_CPU-1:0]          grant,
  output logic [ADDR_W-1:0]           addr_out,
  output logic [NUM_CPU-1:0]          search,
  output logic [NUM_CPU-1:0]          invalidate,
  output logic [NUM_CPU-1:0]          wback,
  output logic [NUM_CPU-1:0]          datasel,
  output logic                        busy,
  output logic [NUM_CPU-1:0]          done
);

  localparam int IDX_W = idx_w(NUM_CPU);

  bus_state_e         state_q, state_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               op_wr_q, op_wr_d;
  logic [NUM_CPU-1:0] found_q, found_d;
  logic [NUM_CPU-1:0] owner_q, owner_d;

  logic [NUM_CPU-1:0] any_req;
  logic [NUM_CPU-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [ADDR_W-1:0]  arb_addr;
  logic [NUM_CPU-1:0] grant_oh;
  logic [NUM_CPU-1:0] found_now;
  logic [NUM_CPU-1:0] m_now;
  logic [NUM_CPU-1:0] owner_now;

  assign any_req = req_rd | req_wr;

  rr_arbiter #(.N(NUM_CPU)) u_arb (
    .req     (any_req),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .req_any (arb_any)
  );

  // Address of the arbitration winner, selected with its one-hot grant.
  always_comb begin
    arb_addr = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      arb_addr = arb_addr | ({ADDR_W{arb_gnt[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    grant_oh           = '0;
    grant_oh[win_idx_q] = 1'b1;
  end

  // The requester's own cache never counts as a holder. With several M
  // holders (protocol error) the lowest index becomes the owner.
  always_comb begin
    logic taken;
    found_now = snoop_found & ~grant_oh;
    m_now     = '0;
    owner_now = '0;
    taken     = 1'b0;
    for (int i = 0; i < NUM_CPU; i++) begin
      m_now[i] = found_now[i] && (blk_state_e'(snoop_state[2*i +: 2]) == BLK_M);
      if (m_now[i] && !taken) begin
        owner_now[i] = 1'b1;
        taken        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_idx_d = win_idx_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    op_wr_d   = op_wr_q;
    found_d   = found_q;
    owner_d   = owner_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          win_idx_d = arb_idx;
          addr_d    = arb_addr;
          op_wr_d   = |(req_wr & arb_gnt);
          state_d   = SNOOP;
        end
      end
      SNOOP: state_d = RESP;
      RESP: begin
        found_d = found_now;
        owner_d = owner_now;
        if (|m_now) begin
          state_d = WBACK;
        end else if (op_wr_q && (|found_now)) begin
          state_d = INVAL;
        end else begin
          state_d = FILL;
        end
      end
      WBACK: begin
        if (wback_done) begin
          state_d = op_wr_q ? INVAL : FILL;
        end
      end
      INVAL: state_d = FILL;
      FILL: begin
        rr_ptr_d = (win_idx_q == IDX_W'(NUM_CPU - 1)) ? '0 : win_idx_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_idx_q <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      op_wr_q   <= 1'b0;
      found_q   <= '0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      op_wr_q   <= op_wr_d;
      found_q   <= found_d;
      owner_q   <= owner_d;
    end
  end

  // More than one Modified holder means the caches disagree about ownership.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP) begin
      assert ($onehot0(m_now));
    end
  end

  // Outputs are pure state decode, so reset or IDLE drives every strobe low.
  assign busy       = (state_q != IDLE);
  assign grant      = busy ? grant_oh : '0;
  assign addr_out   = addr_q;
  assign search     = (state_q == SNOOP) ? ~grant_oh : '0;
  assign invalidate = (state_q == INVAL) ? found_q   : '0;
  assign wback      = (state_q == WBACK) ? owner_q   : '0;
  assign datasel    = (state_q == FILL)  ? grant_oh  : '0;
  assign done       = (state_q == FILL)  ? grant_oh  : '0;

endmodule
